// File: rtl/note_arbiter_if.sv
// Keyboard-to-display handshake bundle for the note arbiter.
// The key source and frame timing drive it; the arbiter answers with the displayed note.
interface note_arbiter_if #(
    parameter int NKEYS = 48
) ();
    logic [NKEYS-1:0] key_down;
    logic             frame_start;
    logic [5:0]       arbiter;
    logic             note_valid;
    logic             note_change;
    logic             busy;

    modport master (
        output key_down,
        output frame_start,
        input  arbiter,
        input  note_valid,
        input  note_change,
        input  busy
    );

    modport slave (
        input  key_down,
        input  frame_start,
        output arbiter,
        output note_valid,
        output note_change,
        output busy
    );
endinterface

// File: rtl/note_arbiter.sv
// Last-note-priority key arbiter: tracks the most recently pressed key, falls back to a
// linear scan of held keys on release, and presents the result tear-free at frame start.
module note_arbiter #(
    parameter int         NKEYS     = 48,
    parameter logic [5:0] IDLE_CODE = 6'd63
) (
    input  logic          clk,
    input  logic          rst,
    note_arbiter_if.slave bus
);

    localparam logic [5:0] LAST_IDX = 6'(NKEYS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    state_t           state_reg, state_next;
    logic [5:0]       cur_reg, cur_next;
    logic [5:0]       idx_reg, idx_next;
    logic [NKEYS-1:0] key_q_reg;
    logic [NKEYS-1:0] rise;
    logic             rise_any;
    logic [5:0]       rise_idx;
    logic [63:0]      key_ext;

    logic [5:0]       arbiter_reg;
    logic             note_valid_reg;
    logic             note_change_reg;

    // Zero-extended view so a 6-bit index can never select a nonexistent key.
    assign key_ext = 64'(bus.key_down);

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_rise
            assign rise[gi] = bus.key_down[gi] & ~key_q_reg[gi];
        end
    endgenerate

    assign rise_any = |rise;

    // Lowest rising index wins when several keys go down in the same cycle.
    always_comb begin
        rise_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                rise_idx = 6'(i);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rise_any) begin
                    cur_next   = rise_idx;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (rise_any) begin
                    cur_next = rise_idx;
                end else if (!key_ext[cur_reg]) begin
                    state_next = ST_SCAN;
                    idx_next   = '0;
                end
            end
            ST_SCAN: begin
                // A fresh press beats whatever the scan might find.
                if (rise_any) begin
                    cur_next   = rise_idx;
                    state_next = ST_HOLD;
                    idx_next   = '0;
                end else if (key_ext[idx_reg]) begin
                    cur_next   = idx_reg;
                    state_next = ST_HOLD;
                    idx_next   = '0;
                end else if (idx_reg == LAST_IDX) begin
                    cur_next   = IDLE_CODE;
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 6'd1;
                end
            end
            default: begin
                cur_next   = IDLE_CODE;
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cur_reg   <= IDLE_CODE;
            idx_reg   <= '0;
            key_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            idx_reg   <= idx_next;
            key_q_reg <= bus.key_down;
        end
    end

    // Display side only moves at frame start, using cur as it stood before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            arbiter_reg     <= IDLE_CODE;
            note_valid_reg  <= 1'b0;
            note_change_reg <= 1'b0;
        end else if (bus.frame_start) begin
            arbiter_reg     <= cur_reg;
            note_valid_reg  <= (cur_reg != IDLE_CODE);
            note_change_reg <= (cur_reg != arbiter_reg);
        end else begin
            note_change_reg <= 1'b0;
        end
    end

    assign bus.arbiter     = arbiter_reg;
    assign bus.note_valid  = note_valid_reg;
    assign bus.note_change = note_change_reg;
    assign bus.busy        = (state_reg == ST_SCAN);

endmodule

// File: tb/tb_note_arbiter.sv
// Self-checking bench for note_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_note_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    note_arbiter_if #(.NKEYS(48)) bus ();

    note_arbiter #(
        .NKEYS    (48),
        .IDLE_CODE(6'd63)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: cur is the current note (63 = none); m_scan is the fallback search
    // position, -1 when no search is in progress.
    bit [47:0] m_keyq;
    int        m_cur;
    int        m_scan;
    int        m_arb;
    bit        m_valid;
    bit        m_change;

    task automatic model_step();
        bit [47:0] kd;
        bit [47:0] rz;
        int        low;
        kd = bus.key_down;
        if (rst) begin
            m_keyq = '0; m_cur = 63; m_scan = -1;
            m_arb = 63; m_valid = 1'b0; m_change = 1'b0;
            return;
        end
        rz  = kd & ~m_keyq;
        low = -1;
        for (int i = 0; i < 48; i++) if (rz[i] && low < 0) low = i;
        if (bus.frame_start) begin
            m_change = (m_cur != m_arb);
            m_arb    = m_cur;
            m_valid  = (m_arb != 63);
        end else begin
            m_change = 1'b0;
        end
        if (low >= 0) begin
            m_cur = low; m_scan = -1;
        end else if (m_scan >= 0) begin
            if (kd[m_scan]) begin
                m_cur = m_scan; m_scan = -1;
            end else if (m_scan == 47) begin
                m_cur = 63; m_scan = -1;
            end else begin
                m_scan = m_scan + 1;
            end
        end else if (m_cur != 63 && !kd[m_cur]) begin
            m_scan = 0;
        end
        m_keyq = kd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.key_down = '0;
        bus.frame_start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.key_down = 48'hFFFF_FFFF_FFFF;
        bus.frame_start = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        bus.frame_start = 1'b0;
        n_checks++; if (bus.arbiter !== 6'd63) begin n_errors++; $display("FAIL reset_arbiter got %0d want 63", bus.arbiter); end
        n_checks++; if (bus.note_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", bus.note_valid); end
        n_checks++; if (bus.note_change !== 1'b0) begin n_errors++; $display("FAIL reset_change got %b want 0", bus.note_change); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        bus.key_down = '0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_press();
        int cnt;
        do_reset();
        repeat (5) tick();
        bus.key_down[13] = 1'b1;
        tick();
        frame();
        n_checks++; if (bus.arbiter !== 6'd13) begin n_errors++; $display("FAIL single_arbiter got %0d want 13", bus.arbiter); end
        n_checks++; if (bus.note_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid got %b want 1", bus.note_valid); end
        n_checks++; if (bus.note_change !== 1'b1) begin n_errors++; $display("FAIL single_change got %b want 1", bus.note_change); end
        tick();
        n_checks++; if (bus.note_change !== 1'b0) begin n_errors++; $display("FAIL single_change_pulse got %b want 0", bus.note_change); end
        bus.key_down[13] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.busy === 1'b1) cnt++;
        end
        n_checks++; if (cnt != 48) begin n_errors++; $display("FAIL worst_scan_busy got %0d want 48", cnt); end
        n_checks++; if (bus.arbiter !== 6'd13) begin n_errors++; $display("FAIL tear_free got %0d want 13", bus.arbiter); end
        frame();
        n_checks++; if (bus.arbiter !== 6'd63) begin n_errors++; $display("FAIL release_arbiter got %0d want 63", bus.arbiter); end
        n_checks++; if (bus.note_valid !== 1'b0) begin n_errors++; $display("FAIL release_valid got %b want 0", bus.note_valid); end
        n_checks++; if (bus.note_change !== 1'b1) begin n_errors++; $display("FAIL release_change got %b want 1", bus.note_change); end
        $display("test_single_press done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.key_down[30] = 1'b1;
        bus.key_down[7]  = 1'b1;
        tick();
        frame();
        n_checks++; if (bus.arbiter !== 6'd7) begin n_errors++; $display("FAIL simultaneous got %0d want 7", bus.arbiter); end
        $display("test_simultaneous done");
    endtask

    task automatic test_fallback();
        int cnt;
        do_reset();
        bus.key_down[40] = 1'b1;
        tick();
        bus.key_down[2] = 1'b1;
        tick();
        bus.key_down[2] = 1'b0;
        tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy !== 1'b1) break;
            cnt++;
            tick();
        end
        n_checks++; if (cnt != 41) begin n_errors++; $display("FAIL fallback_busy got %0d want 41", cnt); end
        frame();
        n_checks++; if (bus.arbiter !== 6'd40) begin n_errors++; $display("FAIL fallback_arbiter got %0d want 40", bus.arbiter); end
        $display("test_fallback done");
    endtask

    task automatic test_scan_abort();
        do_reset();
        bus.key_down[40] = 1'b1;
        tick();
        bus.key_down[40] = 1'b0;
        tick();
        repeat (10) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL abort_scanning got %b want 1", bus.busy); end
        bus.key_down[45] = 1'b1;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        frame();
        n_checks++; if (bus.arbiter !== 6'd45) begin n_errors++; $display("FAIL abort_arbiter got %0d want 45", bus.arbiter); end
        $display("test_scan_abort done");
    endtask

    task automatic test_frame_sync();
        do_reset();
        bus.key_down[5] = 1'b1;
        tick();
        frame();
        bus.key_down[20] = 1'b1;
        frame();
        n_checks++; if (bus.arbiter !== 6'd5) begin n_errors++; $display("FAIL coincident_arbiter got %0d want 5", bus.arbiter); end
        n_checks++; if (bus.note_change !== 1'b0) begin n_errors++; $display("FAIL coincident_change got %b want 0", bus.note_change); end
        frame();
        n_checks++; if (bus.arbiter !== 6'd20) begin n_errors++; $display("FAIL next_frame_arbiter got %0d want 20", bus.arbiter); end
        n_checks++; if (bus.note_change !== 1'b1) begin n_errors++; $display("FAIL next_frame_change got %b want 1", bus.note_change); end
        frame();
        n_checks++; if (bus.note_change !== 1'b0) begin n_errors++; $display("FAIL repeat_frame_change got %b want 0", bus.note_change); end
        $display("test_frame_sync done");
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        bus.key_down[47] = 1'b1;
        tick();
        frame();
        bus.key_down[3] = 1'b1;
        tick();
        bus.key_down[3] = 1'b0;
        tick();
        repeat (25) tick();
        n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL midscan_busy_before got %b want 1", bus.busy); end
        rst = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        n_checks++; if (bus.arbiter !== 6'd63) begin n_errors++; $display("FAIL midscan_rst_arbiter got %0d want 63", bus.arbiter); end
        n_checks++; if (bus.note_valid !== 1'b0) begin n_errors++; $display("FAIL midscan_rst_valid got %b want 0", bus.note_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midscan_rst_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL post_rst_busy got %b want 0", bus.busy); end
        frame();
        n_checks++; if (bus.arbiter !== 6'd47) begin n_errors++; $display("FAIL post_rst_arbiter got %0d want 47", bus.arbiter); end
        n_checks++; if (bus.note_change !== 1'b1) begin n_errors++; $display("FAIL post_rst_change got %b want 1", bus.note_change); end
        $display("test_reset_mid_scan done");
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = int'($urandom_range(0, 47));
                bus.key_down[k] = ~bus.key_down[k];
            end
            if ($urandom_range(0, 59) == 0) bus.key_down = '0;
            bus.frame_start = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
            n_checks++;
            if (bus.arbiter !== 6'(m_arb) || bus.note_valid !== m_valid ||
                bus.note_change !== m_change || bus.busy !== (m_scan >= 0)) begin
                n_errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d got arb=%0d v=%b c=%b b=%b want arb=%0d v=%b c=%b b=%b",
                             c, bus.arbiter, bus.note_valid, bus.note_change, bus.busy,
                             m_arb, m_valid, m_change, (m_scan >= 0));
                end
            end
        end
        rst = 1'b0;
        bus.frame_start = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.key_down = '0;
        bus.frame_start = 1'b0;
        m_keyq = '0; m_cur = 63; m_scan = -1;
        m_arb = 63; m_valid = 1'b0; m_change = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_fallback();
        test_scan_abort();
        test_frame_sync();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
